nibble_add_sequencer: RTL and testbench



---
 rtl/nibble_add_sequencer_if.sv | 38 +++
 rtl/nibble_add_sequencer.sv | 91 +++++++++
 tb/tb_nibble_add_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/nibble_add_sequencer_if.sv
// rtl/nibble_add_sequencer_if.sv - request/response and adder-slice signal bundle for nibble_add_sequencer
interface nibble_add_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [3:0]       pa_a;
    logic [3:0]       pa_b;
    logic             pa_cin;
    logic [3:0]       pa_sum;
    logic             pa_cout;

    // requester side: issues ops and collects results
    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    // sequencer side: serves the requester and drives the shared slice
    modport slave (
        input  start, sub, a, b, cin, pa_sum, pa_cout,
        output busy, done, sum, cout, ovf, pa_a, pa_b, pa_cin
    );

    // external 4-bit adder slice
    modport slice (
        input  pa_a, pa_b, pa_cin,
        output pa_sum, pa_cout
    );
endinterface

// File: rtl/nibble_add_sequencer.sv
// rtl/nibble_add_sequencer.sv - WIDTH-bit add/sub sequenced one nibble per clock through a shared 4-bit adder slice
module nibble_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_add_sequencer_if.slave bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             busy_r;
    logic             done_r;
    logic             cout_r;
    logic             ovf_r;
    logic [IDXW+1:0]  bit_pos;

    assign bit_pos  = {idx, 2'b00};
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;

    // slice is combinational, so its result for nibble idx is sampled at the same edge
    always_comb begin
        bus.pa_a   = 4'd0;
        bus.pa_b   = 4'd0;
        bus.pa_cin = 1'b0;
        if (state == RUN) begin
            bus.pa_a   = a_r[bit_pos +: 4];
            bus.pa_b   = b_r[bit_pos +: 4];
            bus.pa_cin = carry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // subtract is a + ~b + 1; cin is only meaningful for add
                        a_r    <= bus.a;
                        b_r    <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub ? 1'b1 : bus.cin;
                        idx    <= '0;
                        sum_r  <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_r[bit_pos +: 4] <= bus.pa_sum;
                    carry               <= bus.pa_cout;
                    idx                 <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout_r <= bus.pa_cout;
                        ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                  (bus.pa_sum[3] != a_r[WIDTH-1]);
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        idx    <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb/tb_nibble_add_sequencer.sv - directed self-checking bench for nibble_add_sequencer
module tb_nibble_add_sequencer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   done_cnt;

    nibble_add_sequencer_if #(.WIDTH(16)) bus ();

    nibble_add_sequencer #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model of the external 4-bit ripple-carry slice
    always_comb begin
        {bus.pa_cout, bus.pa_sum} = {1'b0, bus.pa_a} + {1'b0, bus.pa_b} + {4'd0, bus.pa_cin};
    end

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                          input logic op_cin, input logic op_sub, input logic [15:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
        int          lat;
        int          base;
        logic [15:0] seq;
        base      = done_cnt;
        seq       = 16'h0;
        lat       = 0;
        bus.a     = op_a;
        bus.b     = op_b;
        bus.cin   = op_cin;
        bus.sub   = op_sub;
        bus.start = 1'b1;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            lat++;
            if (bus.done !== 1'b1 && lat <= 4) seq[4*(lat-1) +: 4] = bus.pa_a;
        end while (bus.done !== 1'b1 && lat < 20);
        check_val({tag, " latency"}, 32'(lat - 1), 32'd4);
        check_val({tag, " sum"}, {16'h0, bus.sum}, {16'h0, exp_sum});
        check_val({tag, " cout"}, {31'h0, bus.cout}, {31'h0, exp_cout});
        check_val({tag, " ovf"}, {31'h0, bus.ovf}, {31'h0, exp_ovf});
        check_val({tag, " busy_at_done"}, {31'h0, bus.busy}, 32'h0);
        check_val({tag, " pa_a_seq"}, {16'h0, seq}, {16'h0, op_a});
        check_val({tag, " pa_idle"}, {23'h0, bus.pa_a, bus.pa_b, bus.pa_cin}, 32'h0);
        @(negedge clk);
        check_val({tag, " done_pulse"}, {31'h0, bus.done}, 32'h0);
        check_val({tag, " sum_held"}, {16'h0, bus.sum}, {16'h0, exp_sum});
        check_val({tag, " done_count"}, 32'(done_cnt - base), 32'd1);
    endtask

    initial begin
        int base;
        int lat;
        n_cmp     = 0;
        n_err     = 0;
        done_cnt  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = 16'h0;
        bus.b     = 16'h0;
        bus.cin   = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst busy", {31'h0, bus.busy}, 32'h0);
        check_val("rst done", {31'h0, bus.done}, 32'h0);
        check_val("rst sum", {16'h0, bus.sum}, 32'h0);
        check_val("rst cout_ovf", {30'h0, bus.cout, bus.ovf}, 32'h0);
        check_val("rst pa", {23'h0, bus.pa_a, bus.pa_b, bus.pa_cin}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("t1_add",       16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("t2_ripple",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("t2_cin",       16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("t3_sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("t3_sub_pos",   16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_op("t4_add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("t4_sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // start while busy is ignored, then back-to-back start in the done cycle
        base      = done_cnt;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a     = 16'hAAAA;
        bus.b     = 16'h5555;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        lat = 3;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_val("t5 busy_start_latency", 32'(lat - 1), 32'd4);
        check_val("t5 ignored_sum", {16'h0, bus.sum}, 32'h3333);
        bus.a     = 16'h0F0F;
        bus.b     = 16'h0101;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        check_val("t5 b2b_done_drop", {31'h0, bus.done}, 32'h0);
        check_val("t5 b2b_busy", {31'h0, bus.busy}, 32'h1);
        check_val("t5 b2b_sum_clear", {16'h0, bus.sum}, 32'h0);
        check_val("t5 single_done", 32'(done_cnt - base), 32'd1);
        while (bus.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_val("t5 b2b_latency", 32'(lat - 1), 32'd4);
        check_val("t5 b2b_sum", {16'h0, bus.sum}, 32'h1010);
        @(negedge clk);

        // reset during the third RUN cycle aborts the op with no done pulse
        base      = done_cnt;
        bus.a     = 16'h1234;
        bus.b     = 16'h1111;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_val("t6 rst_busy", {31'h0, bus.busy}, 32'h0);
        check_val("t6 rst_sum", {16'h0, bus.sum}, 32'h0);
        check_val("t6 rst_done", {31'h0, bus.done}, 32'h0);
        repeat (6) @(negedge clk);
        check_val("t6 no_done", 32'(done_cnt - base), 32'd0);
        check_val("t6 idle_busy", {31'h0, bus.busy}, 32'h0);
        run_op("t6_fresh", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
